// File: rtl/nand_flash_responder_if.sv
// rtl/nand_flash_responder_if.sv - NAND flash pin bundle between host and responder
interface nand_flash_responder_if;
  logic       cle;
  logic       ale;
  logic       ce;
  logic       we;
  logic       re;
  logic       se;
  logic       wp;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic       io_oe;
  logic       ready;
  logic [7:0] cmd_seen;

  modport master (
    output cle, ale, ce, we, re, se, wp, io_in,
    input  io_out, io_oe, ready, cmd_seen
  );

  modport slave (
    input  cle, ale, ce, we, re, se, wp, io_in,
    output io_out, io_oe, ready, cmd_seen
  );
endinterface

// File: rtl/nand_flash_responder.sv
// rtl/nand_flash_responder.sv - device-side NAND flash responder with small page array
module nand_flash_responder #(
  parameter int PAGE_BYTES  = 16,
  parameter int SPARE_BYTES = 4,
  parameter int PAGES       = 4,
  parameter int READ_BUSY   = 8,
  parameter int PROG_BUSY   = 32,
  parameter int RST_BUSY    = 4
) (
  input logic                   clk,
  input logic                   reset,
  nand_flash_responder_if.slave bus
);
  localparam int LB = PAGE_BYTES + SPARE_BYTES;
  localparam int CW = $clog2(PAGE_BYTES);
  localparam int LW = $clog2(LB);
  localparam int RW = $clog2(PAGES);

  typedef enum logic [2:0] {IDLE, ADDR, DATA_IN, BUSY, DATA_OUT, STATUS} state_t;
  state_t state, state_d;

  logic          we_q, re_q;
  logic [CW-1:0] column;
  logic [RW-1:0] row;
  logic          spare, op_prog, busy_to_read, commit_pending, addr_cnt;
  logic [15:0]   busy_cnt;
  logic [7:0]    status, io_out_r, cmd_seen_r;
  logic [7:0]    latch [LB];
  logic [7:0]    mem [PAGES][LB];
  logic [PAGES-1:0] page_valid;

  logic          we_rise, re_fall, cmd_cyc, addr_cyc, data_cyc, not_busy, ready_w;
  logic          cmd_ff, cmd_rd, cmd_pg, cmd_st, cmd_cf;
  logic          addr_first, addr_last, busy_done, commit_now;
  logic [CW-1:0] col_mask, col_mask_new, col_next;
  logic [LW-1:0] idx;
  logic [RW-1:0] row_new;

  assign we_rise  = ~we_q & bus.we & ~bus.ce;
  assign re_fall  = re_q & ~bus.re & ~bus.ce;
  assign cmd_cyc  = we_rise & bus.cle & ~bus.ale;
  assign addr_cyc = we_rise & bus.ale & ~bus.cle;
  assign data_cyc = we_rise & ~bus.cle & ~bus.ale;
  assign not_busy = (state != BUSY);

  assign cmd_ff = cmd_cyc & (bus.io_in == 8'hFF);
  assign cmd_rd = cmd_cyc & not_busy & (bus.io_in == 8'h00);
  assign cmd_pg = cmd_cyc & not_busy & (bus.io_in == 8'h80);
  assign cmd_st = cmd_cyc & not_busy & (bus.io_in == 8'h70);
  assign cmd_cf = cmd_cyc & (state == DATA_IN) & (bus.io_in == 8'h10);

  assign addr_first = addr_cyc & (state == ADDR) & ~addr_cnt;
  assign addr_last  = addr_cyc & (state == ADDR) & addr_cnt;
  assign busy_done  = (state == BUSY) & (busy_cnt == 16'd0);
  assign commit_now = busy_done & commit_pending & ~cmd_ff;

  // Spare selection is latched at the first address byte and holds for the whole op
  assign col_mask     = spare   ? CW'(SPARE_BYTES - 1) : CW'(PAGE_BYTES - 1);
  assign col_mask_new = ~bus.se ? CW'(SPARE_BYTES - 1) : CW'(PAGE_BYTES - 1);
  assign col_next     = (column + CW'(1)) & col_mask;
  assign idx          = spare ? LW'(PAGE_BYTES) + LW'(column) : LW'(column);
  assign row_new      = bus.io_in[RW-1:0];

  assign ready_w      = not_busy;
  assign bus.ready    = ready_w;
  assign bus.io_out   = io_out_r;
  assign bus.cmd_seen = cmd_seen_r;
  assign bus.io_oe    = ~bus.ce & ~bus.re & ((state == DATA_OUT) | (state == STATUS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (cmd_ff)               state_d = BUSY;
    else if (cmd_rd | cmd_pg) state_d = ADDR;
    else if (cmd_st)          state_d = STATUS;
    else if (cmd_cf)          state_d = BUSY;
    else begin
      case (state)
        ADDR:    if (addr_last) state_d = op_prog ? DATA_IN : BUSY;
        BUSY:    if (busy_done) state_d = busy_to_read ? DATA_OUT : IDLE;
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q           <= 1'b1;
      re_q           <= 1'b1;
      column         <= '0;
      row            <= '0;
      spare          <= 1'b0;
      op_prog        <= 1'b0;
      busy_to_read   <= 1'b0;
      commit_pending <= 1'b0;
      addr_cnt       <= 1'b0;
      busy_cnt       <= 16'd0;
      status         <= 8'hC0;
      io_out_r       <= 8'h00;
      cmd_seen_r     <= 8'h00;
      page_valid     <= '0;
      for (int i = 0; i < LB; i++) latch[i] <= 8'hFF;
    end else begin
      we_q <= bus.we;
      re_q <= bus.re;
      if (cmd_ff) begin
        column         <= '0;
        row            <= '0;
        spare          <= 1'b0;
        busy_to_read   <= 1'b0;
        commit_pending <= 1'b0;
        busy_cnt       <= 16'(RST_BUSY - 1);
      end else if (cmd_rd | cmd_pg) begin
        op_prog  <= cmd_pg;
        addr_cnt <= 1'b0;
        spare    <= 1'b0;
      end else if (cmd_cf) begin
        busy_cnt       <= 16'(PROG_BUSY - 1);
        busy_to_read   <= 1'b0;
        commit_pending <= bus.wp;
        status         <= bus.wp ? 8'hC0 : 8'h41;
      end else if (addr_first) begin
        column   <= bus.io_in[CW-1:0] & col_mask_new;
        spare    <= ~bus.se;
        addr_cnt <= 1'b1;
      end else if (addr_last) begin
        row <= row_new;
        if (op_prog) begin
          for (int i = 0; i < LB; i++) latch[i] <= 8'hFF;
        end else begin
          for (int i = 0; i < LB; i++)
            latch[i] <= page_valid[row_new] ? mem[row_new][i] : 8'hFF;
          busy_cnt     <= 16'(READ_BUSY - 1);
          busy_to_read <= 1'b1;
        end
      end else if (data_cyc && state == DATA_IN) begin
        latch[idx] <= bus.io_in;
        column     <= col_next;
      end else if (re_fall && state == DATA_OUT) begin
        io_out_r <= latch[idx];
        column   <= col_next;
      end else if (state == BUSY) begin
        if (busy_cnt != 16'd0) begin
          busy_cnt <= busy_cnt - 16'd1;
        end else begin
          commit_pending <= 1'b0;
          if (commit_pending) page_valid[row] <= 1'b1;
        end
      end
      if (state == STATUS) io_out_r <= {status[7], ready_w, 5'b0, status[0]};
      if (cmd_ff | cmd_rd | cmd_pg | cmd_st | cmd_cf) cmd_seen_r <= bus.io_in;
    end
  end

  // Erased cells read as 1s, so a program can only clear bits of a valid page
  always_ff @(posedge clk) begin
    if (commit_now)
      for (int i = 0; i < LB; i++)
        mem[row][i] <= page_valid[row] ? (mem[row][i] & latch[i]) : latch[i];
  end
endmodule

// File: tb/tb_nand_flash_responder.sv
// tb/tb_nand_flash_responder.sv - directed self-checking bench for nand_flash_responder
module tb_nand_flash_responder;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  nand_flash_responder_if nif ();
  nand_flash_responder dut (.clk(clk), .reset(reset), .bus(nif));

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic c, input logic a, input logic [7:0] d);
    nif.cle = c; nif.ale = a; nif.io_in = d; nif.we = 1'b0;
    cyc(1);
    nif.we = 1'b1;
    cyc(1);
    nif.cle = 1'b0; nif.ale = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] d); wr(1'b1, 1'b0, d); endtask
  task automatic adr(input logic [7:0] d); wr(1'b0, 1'b1, d); endtask
  task automatic dat(input logic [7:0] d); wr(1'b0, 1'b0, d); endtask

  task automatic rd(output logic [7:0] v, output logic oe);
    nif.re = 1'b0;
    cyc(1);
    v = nif.io_out; oe = nif.io_oe;
    nif.re = 1'b1;
    cyc(1);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (nif.ready !== 1'b1 && n < 500) begin n++; cyc(1); end
  endtask

  task automatic test_reset;
    nif.cle = 0; nif.ale = 0; nif.ce = 0; nif.we = 1; nif.re = 1;
    nif.se = 1; nif.wp = 1; nif.io_in = 8'h00;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    vectors++; if (nif.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", nif.ready); end
    vectors++; if (nif.io_oe !== 1'b0) begin miscompares++; $display("FAIL reset_io_oe: got %b want 0", nif.io_oe); end
    vectors++; if (nif.io_out !== 8'h00) begin miscompares++; $display("FAIL reset_io_out: got %h want 00", nif.io_out); end
    vectors++; if (nif.cmd_seen !== 8'h00) begin miscompares++; $display("FAIL reset_cmd_seen: got %h want 00", nif.cmd_seen); end
  endtask

  task automatic test_program_read;
    int n; logic [7:0] v; logic oe;
    cmd(8'h80); adr(8'h00); adr(8'h01); dat(8'hA5); dat(8'h5A); cmd(8'h10);
    wait_ready(n);
    vectors++; if (n !== 32) begin miscompares++; $display("FAIL prog_busy: got %0d want 32", n); end
    vectors++; if (nif.cmd_seen !== 8'h10) begin miscompares++; $display("FAIL prog_cmd_seen: got %h want 10", nif.cmd_seen); end
    cmd(8'h00); adr(8'h00); adr(8'h01);
    wait_ready(n);
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL read_busy: got %0d want 8", n); end
    rd(v, oe);
    vectors++; if (v !== 8'hA5) begin miscompares++; $display("FAIL read_b0: got %h want A5", v); end
    vectors++; if (oe !== 1'b1) begin miscompares++; $display("FAIL read_oe: got %b want 1", oe); end
    rd(v, oe);
    vectors++; if (v !== 8'h5A) begin miscompares++; $display("FAIL read_b1: got %h want 5A", v); end
    rd(v, oe);
    vectors++; if (v !== 8'hFF) begin miscompares++; $display("FAIL read_b2: got %h want FF", v); end
    vectors++; if (nif.io_oe !== 1'b0) begin miscompares++; $display("FAIL read_oe_idle: got %b want 0", nif.io_oe); end
  endtask

  task automatic test_write_protect;
    int n; logic [7:0] v; logic oe;
    nif.wp = 1'b0;
    cmd(8'h80); adr(8'h00); adr(8'h02); dat(8'h3C); cmd(8'h10);
    wait_ready(n);
    nif.wp = 1'b1;
    vectors++; if (n !== 32) begin miscompares++; $display("FAIL wp_busy: got %0d want 32", n); end
    cmd(8'h70);
    nif.re = 1'b0;
    cyc(1);
    vectors++; if (nif.io_out !== 8'h41) begin miscompares++; $display("FAIL wp_status: got %h want 41", nif.io_out); end
    vectors++; if (nif.io_oe !== 1'b1) begin miscompares++; $display("FAIL wp_status_oe: got %b want 1", nif.io_oe); end
    nif.re = 1'b1;
    cyc(1);
    cmd(8'h00); adr(8'h00); adr(8'h02);
    wait_ready(n);
    rd(v, oe);
    vectors++; if (v !== 8'hFF) begin miscompares++; $display("FAIL wp_page_b0: got %h want FF", v); end
    rd(v, oe);
    vectors++; if (v !== 8'hFF) begin miscompares++; $display("FAIL wp_page_b1: got %h want FF", v); end
  endtask

  task automatic test_column_wrap;
    int n; logic [7:0] v; logic oe;
    cmd(8'h80); adr(8'h0F); adr(8'h03); dat(8'h77); dat(8'h88); cmd(8'h10);
    wait_ready(n);
    cmd(8'h00); adr(8'h0F); adr(8'h03);
    wait_ready(n);
    rd(v, oe);
    vectors++; if (v !== 8'h77) begin miscompares++; $display("FAIL wrap_b15: got %h want 77", v); end
    rd(v, oe);
    vectors++; if (v !== 8'h88) begin miscompares++; $display("FAIL wrap_b0: got %h want 88", v); end
  endtask

  task automatic test_spare;
    int n; logic [7:0] v; logic oe;
    logic [7:0] exp_q [5];
    exp_q = '{8'h33, 8'hFF, 8'h11, 8'h22, 8'h33};
    cmd(8'h80); nif.se = 1'b0; adr(8'h02); nif.se = 1'b1; adr(8'h00);
    dat(8'h11); dat(8'h22); dat(8'h33); cmd(8'h10);
    wait_ready(n);
    cmd(8'h00); nif.se = 1'b0; adr(8'h00); nif.se = 1'b1; adr(8'h00);
    wait_ready(n);
    for (int i = 0; i < 5; i++) begin
      rd(v, oe);
      vectors++; if (v !== exp_q[i]) begin miscompares++; $display("FAIL spare_b%0d: got %h want %h", i, v, exp_q[i]); end
    end
    cmd(8'h00); adr(8'h00); adr(8'h00);
    wait_ready(n);
    rd(v, oe);
    vectors++; if (v !== 8'hFF) begin miscompares++; $display("FAIL spare_main_b0: got %h want FF", v); end
  endtask

  task automatic test_and_merge;
    int n; logic [7:0] v; logic oe;
    cmd(8'h80); adr(8'h00); adr(8'h01); dat(8'h0F); cmd(8'h10);
    wait_ready(n);
    cmd(8'h00); adr(8'h00); adr(8'h01);
    wait_ready(n);
    rd(v, oe);
    vectors++; if (v !== 8'h05) begin miscompares++; $display("FAIL and_b0: got %h want 05", v); end
    rd(v, oe);
    vectors++; if (v !== 8'h5A) begin miscompares++; $display("FAIL and_b1: got %h want 5A", v); end
  endtask

  task automatic test_reset_abort;
    int n; logic [7:0] v; logic oe;
    cmd(8'h80); adr(8'h01); adr(8'h01); dat(8'h00); cmd(8'h10);
    cyc(9);
    cmd(8'hFF);
    wait_ready(n);
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL abort_busy: got %0d want 4", n); end
    vectors++; if (nif.cmd_seen !== 8'hFF) begin miscompares++; $display("FAIL abort_cmd_seen: got %h want FF", nif.cmd_seen); end
    cmd(8'h00); adr(8'h01); adr(8'h01);
    wait_ready(n);
    rd(v, oe);
    vectors++; if (v !== 8'h5A) begin miscompares++; $display("FAIL abort_page: got %h want 5A", v); end
    nif.ce = 1'b1;
    cmd(8'h70);
    vectors++; if (nif.cmd_seen !== 8'h00) begin miscompares++; $display("FAIL ce_cmd_seen: got %h want 00", nif.cmd_seen); end
    nif.re = 1'b0;
    cyc(1);
    vectors++; if (nif.io_oe !== 1'b0) begin miscompares++; $display("FAIL ce_io_oe: got %b want 0", nif.io_oe); end
    nif.re = 1'b1;
    cyc(1);
    nif.ce = 1'b0;
    cyc(1);
    rd(v, oe);
    vectors++; if (v !== 8'hFF) begin miscompares++; $display("FAIL ce_next_byte: got %h want FF", v); end
  endtask

  task automatic test_async_reset;
    logic [7:0] v; logic oe;
    cmd(8'h80); adr(8'h00); adr(8'h01); dat(8'h00);
    #2 reset = 1'b1;
    #1;
    vectors++; if (nif.cmd_seen !== 8'h00) begin miscompares++; $display("FAIL async_cmd_seen: got %h want 00", nif.cmd_seen); end
    vectors++; if (nif.ready !== 1'b1) begin miscompares++; $display("FAIL async_ready: got %b want 1", nif.ready); end
    cyc(1);
    reset = 1'b0;
    cyc(1);
    rd(v, oe);
    vectors++; if (oe !== 1'b0) begin miscompares++; $display("FAIL async_idle_oe: got %b want 0", oe); end
  endtask

  initial begin
    test_reset;
    test_program_read;
    test_write_protect;
    test_column_wrap;
    test_spare;
    test_and_merge;
    test_reset_abort;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
